rr_pop_stage: RTL and testbench

- Stage directly downstream of the weighted round-robin arbiter.
- Turns the arbiter's selector/selector_enb into a one-hot pop strobe for the FIFO bank.
- Muxes the selected queue's head word into a 2-entry output skid buffer with valid/ready handshake.
- Keeps per-queue pop counters for statistics and flags illegal pop requests.

---
 rtl/rr_pop_stage.sv | 112 +++++++++++
 tb/tb_rr_pop_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_pop_stage.sv
// rtl/rr_pop_stage.sv - round-robin pop strobe generator with 2-entry output skid buffer
// Converts the arbiter selection into a one-hot FIFO pop and buffers the popped word.
module rr_pop_stage #(
    parameter int QUEUE_QUANTITY = 4,
    parameter int DATA_BITS      = 8,
    parameter int CNT_BITS       = 16,
    localparam int SEL_BITS      = $clog2(QUEUE_QUANTITY)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enb,
    input  logic [SEL_BITS-1:0]                selector,
    input  logic                               selector_enb,
    input  logic [QUEUE_QUANTITY-1:0]          buf_empty,
    input  logic [QUEUE_QUANTITY*DATA_BITS-1:0] fifo_data_out,
    output logic [QUEUE_QUANTITY-1:0]          pop,
    output logic [DATA_BITS-1:0]               data_out,
    output logic [SEL_BITS-1:0]                queue_out,
    output logic                               data_valid,
    input  logic                               out_ready,
    output logic [QUEUE_QUANTITY*CNT_BITS-1:0] pop_count,
    output logic                               err_underflow
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    occ_t                 occ;
    logic [DATA_BITS-1:0] data_mem [2];
    logic [SEL_BITS-1:0]  qid_mem  [2];
    logic                 rd_ptr;
    logic                 wr_ptr;
    logic [CNT_BITS-1:0]  cnt [QUEUE_QUANTITY];

    logic                 space;
    logic                 sel_empty;
    logic [DATA_BITS-1:0] sel_data;
    logic                 push;
    logic                 drain;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < QUEUE_QUANTITY; i++) begin
            if (SEL_BITS'(i) == selector) begin
                sel_data = fifo_data_out[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    // space comes from registered occupancy only, so out_ready never reaches pop
    assign space     = (occ != FULL);
    assign sel_empty = buf_empty[selector];
    assign push      = !rst && enb && selector_enb && !sel_empty && space;
    assign drain     = (occ != EMPTY) && out_ready;

    always_comb begin
        pop           = '0;
        pop[selector] = push;
    end

    assign data_out   = data_mem[rd_ptr];
    assign queue_out  = qid_mem[rd_ptr];
    assign data_valid = (occ != EMPTY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ           <= EMPTY;
            rd_ptr        <= 1'b0;
            wr_ptr        <= 1'b0;
            err_underflow <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                data_mem[i] <= '0;
                qid_mem[i]  <= '0;
            end
            for (int i = 0; i < QUEUE_QUANTITY; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            if (push) begin
                data_mem[wr_ptr] <= sel_data;
                qid_mem[wr_ptr]  <= selector;
                wr_ptr           <= ~wr_ptr;
            end
            if (drain) begin
                rd_ptr <= ~rd_ptr;
            end
            case (occ)
                EMPTY:   if (push) occ <= ONE;
                ONE: begin
                    if (push && !drain)      occ <= FULL;
                    else if (!push && drain) occ <= EMPTY;
                end
                FULL:    if (drain) occ <= ONE;
                default: occ <= EMPTY;
            endcase
            for (int i = 0; i < QUEUE_QUANTITY; i++) begin
                if (pop[i]) cnt[i] <= cnt[i] + CNT_BITS'(1);
            end
            if (enb && selector_enb && sel_empty) begin
                err_underflow <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < QUEUE_QUANTITY; g++) begin : g_cnt
        assign pop_count[g*CNT_BITS +: CNT_BITS] = cnt[g];
    end

endmodule

// File: tb/tb_rr_pop_stage.sv
// tb/tb_rr_pop_stage.sv - self-checking bench for rr_pop_stage
// Vector table, directed corner sequences and a randomized run against a queue model.
module tb_rr_pop_stage;

    localparam int QQ = 4;
    localparam int DB = 8;
    localparam int CB = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           enb = 1'b0;
    logic [1:0]     selector = '0;
    logic           selector_enb = 1'b0;
    logic [QQ-1:0]  buf_empty = '0;
    logic [QQ*DB-1:0] fifo_data_out = '0;
    logic [QQ-1:0]  pop;
    logic [DB-1:0]  data_out;
    logic [1:0]     queue_out;
    logic           data_valid;
    logic           out_ready = 1'b0;
    logic [QQ*CB-1:0] pop_count;
    logic           err_underflow;

    int checks = 0;
    int errors = 0;

    rr_pop_stage #(.QUEUE_QUANTITY(QQ), .DATA_BITS(DB), .CNT_BITS(CB)) dut (
        .clk(clk), .rst(rst), .enb(enb), .selector(selector),
        .selector_enb(selector_enb), .buf_empty(buf_empty),
        .fifo_data_out(fifo_data_out), .pop(pop), .data_out(data_out),
        .queue_out(queue_out), .data_valid(data_valid), .out_ready(out_ready),
        .pop_count(pop_count), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        e;
        bit        se;
        bit [1:0]  sel;
        bit [3:0]  emp;
        bit [7:0]  word;
        bit        rdy;
        bit [3:0]  exp_pop;
        bit        exp_valid;
        bit [7:0]  exp_data;
        bit [1:0]  exp_q;
        bit        exp_err;
    } vec_t;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] q;
    } ent_t;

    ent_t mq[$];
    int   mcnt[QQ];
    bit   merr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit e, input bit se, input bit [1:0] s, input bit [3:0] emp,
                         input bit [7:0] w, input bit rdy);
        enb = e;
        selector_enb = se;
        selector = s;
        buf_empty = emp;
        out_ready = rdy;
        for (int j = 0; j < QQ; j++) begin
            fifo_data_out[j*DB +: DB] = (j == int'(s)) ? w : (w ^ (8'h5A + 8'(j)));
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    function automatic logic [CB-1:0] cnt_of(input int i);
        return pop_count[i*CB +: CB];
    endfunction

    task automatic model_cycle();
        bit       space, push, drain;
        bit [3:0] ep;
        ent_t     h;
        space = mq.size() < 2;
        push  = enb && selector_enb && !buf_empty[selector] && space;
        ep    = push ? 4'(1 << selector) : 4'b0;
        #1;
        chk("rnd_pop", 32'(pop), 32'(ep));
        chk("rnd_valid", 32'(data_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            h = mq[0];
            chk("rnd_data", 32'(data_out), 32'(h.d));
            chk("rnd_queue", 32'(queue_out), 32'(h.q));
        end
        chk("rnd_err", 32'(err_underflow), 32'(merr));
        for (int i = 0; i < QQ; i++) chk("rnd_cnt", 32'(cnt_of(i)), 32'(mcnt[i] % 16));
        drain = (mq.size() != 0) && out_ready;
        @(posedge clk);
        if (drain) void'(mq.pop_front());
        if (push) begin
            mq.push_back({fifo_data_out[selector*DB +: DB], selector});
            mcnt[selector] = mcnt[selector] + 1;
        end
        if (enb && selector_enb && buf_empty[selector]) merr = 1'b1;
        @(negedge clk);
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{1,1,2,4'b0000,8'hA5,1, 4'b0100,0,8'h00,0,0};
        vecs[1]  = '{1,0,2,4'b0000,8'h00,1, 4'b0000,1,8'hA5,2,0};
        vecs[2]  = '{1,1,0,4'b0000,8'h11,0, 4'b0001,0,8'h00,0,0};
        vecs[3]  = '{1,1,1,4'b0000,8'h22,0, 4'b0010,1,8'h11,0,0};
        vecs[4]  = '{1,1,1,4'b0000,8'h33,0, 4'b0000,1,8'h11,0,0};
        vecs[5]  = '{1,1,1,4'b0000,8'h33,1, 4'b0000,1,8'h11,0,0};
        vecs[6]  = '{1,1,1,4'b0000,8'h33,1, 4'b0010,1,8'h22,1,0};
        vecs[7]  = '{1,0,1,4'b0000,8'h00,1, 4'b0000,1,8'h33,1,0};
        vecs[8]  = '{1,0,1,4'b0000,8'h00,1, 4'b0000,0,8'h00,0,0};
        vecs[9]  = '{1,1,1,4'b0010,8'h77,1, 4'b0000,0,8'h00,0,0};
        vecs[10] = '{1,1,0,4'b0000,8'h44,1, 4'b0001,0,8'h00,0,1};
        vecs[11] = '{1,0,0,4'b0000,8'h00,1, 4'b0000,1,8'h44,0,1};

        // reset state, with pop-enabling inputs present
        drive(1, 1, 2, 4'b0000, 8'hA5, 1);
        @(negedge clk);
        #1;
        chk("rst_pop", 32'(pop), 0);
        chk("rst_valid", 32'(data_valid), 0);
        chk("rst_data", 32'(data_out), 0);
        chk("rst_queue", 32'(queue_out), 0);
        chk("rst_cnt", 32'(pop_count), 0);
        chk("rst_err", 32'(err_underflow), 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].e, vecs[i].se, vecs[i].sel, vecs[i].emp, vecs[i].word, vecs[i].rdy);
            #1;
            chk($sformatf("vec%0d_pop", i), 32'(pop), 32'(vecs[i].exp_pop));
            chk($sformatf("vec%0d_valid", i), 32'(data_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                chk($sformatf("vec%0d_data", i), 32'(data_out), 32'(vecs[i].exp_data));
                chk($sformatf("vec%0d_queue", i), 32'(queue_out), 32'(vecs[i].exp_q));
            end
            chk($sformatf("vec%0d_err", i), 32'(err_underflow), 32'(vecs[i].exp_err));
            next_cycle();
        end
        chk("tbl_cnt0", 32'(cnt_of(0)), 2);
        chk("tbl_cnt1", 32'(cnt_of(1)), 2);
        chk("tbl_cnt2", 32'(cnt_of(2)), 1);
        chk("tbl_cnt3", 32'(cnt_of(3)), 0);

        // asynchronous reset mid-stream kills an active pop immediately
        drive(1, 1, 1, 4'b0000, 8'h55, 0);
        next_cycle();
        #1;
        chk("mid_pop_before", 32'(pop), 32'(4'b0010));
        rst = 1'b1;
        #1;
        chk("mid_pop", 32'(pop), 0);
        chk("mid_valid", 32'(data_valid), 0);
        chk("mid_cnt", 32'(pop_count), 0);
        chk("mid_err", 32'(err_underflow), 0);
        @(negedge clk);
        rst = 1'b0;

        // streaming ten words from queue 3
        for (int k = 0; k <= 10; k++) begin
            drive(1, k < 10, 3, 4'b0000, 8'h30 + 8'(k), 1);
            #1;
            chk("str_pop", 32'(pop), (k < 10) ? 32'h8 : 32'h0);
            if (k > 0) begin
                chk("str_valid", 32'(data_valid), 1);
                chk("str_data", 32'(data_out), 32'(8'h30 + 8'(k - 1)));
                chk("str_queue", 32'(queue_out), 3);
            end
            next_cycle();
        end
        chk("str_cnt3", 32'(cnt_of(3)), 10);

        // counter wrap on queue 0
        for (int k = 0; k < 17; k++) begin
            drive(1, 1, 0, 4'b0000, 8'(k), 1);
            next_cycle();
        end
        chk("wrap_cnt0", 32'(cnt_of(0)), 1);
        drive(1, 0, 0, 4'b0000, 8'h00, 1);
        next_cycle();

        // enb=0 blocks pops but the buffer still drains
        drive(1, 1, 1, 4'b0000, 8'h61, 0);
        next_cycle();
        drive(1, 1, 1, 4'b0000, 8'h62, 0);
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 1, 4'b0000, 8'h63, 1);
            #1;
            chk("enb_pop", 32'(pop), 0);
            chk("enb_valid", 32'(data_valid), (k < 2) ? 32'd1 : 32'd0);
            if (k < 2) chk("enb_data", 32'(data_out), 32'(8'h61 + 8'(k)));
            next_cycle();
        end
        chk("enb_cnt1", 32'(cnt_of(1)), 2);

        // randomized traffic against the queue model
        do_reset();
        mq.delete();
        for (int i = 0; i < QQ; i++) mcnt[i] = 0;
        merr = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            enb          = ($urandom % 8) != 0;
            selector_enb = ($urandom % 4) != 0;
            selector     = 2'($urandom);
            for (int j = 0; j < QQ; j++) buf_empty[j] = (n > 1500) ? (($urandom % 12) == 0) : 1'b0;
            out_ready     = ($urandom % 3) != 0;
            fifo_data_out = $urandom;
            model_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
